// File: rtl/pipe_add_sub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The block under the bus is the slave; whoever feeds operands and drains
// results is the master.
interface pipe_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_add_sub.sv
// Pipelined ripple adder/subtractor. The operand is cut into STAGES equal
// slices; each stage adds one slice and hands its carry to the next stage.
// One global advance signal moves the whole pipe, so a stalled output
// freezes every stage (bubbles are kept, not squeezed out).
module pipe_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic           clk,
  input logic           rst_n,
  pipe_add_sub_if.slave bus
);

  localparam int SW = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("pipe_add_sub: WIDTH must be >= 2");
  end
  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_chk_stages
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
  end

  typedef logic [WIDTH-1:0] word_t;

  // One slice add, widened by a bit so the slice carry is never truncated.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
  endfunction

  // Drop a finished slice into its place in the partial result.
  function automatic word_t put_slice(input word_t         w,
                                      input logic [SW-1:0] sl,
                                      input int            k);
    word_t r;
    r = w;
    r[k*SW +: SW] = sl;
    return r;
  endfunction

  logic adv;

  // Stage inputs: index 0 comes from the ports, index k from stage k-1.
  word_t a_i [STAGES];
  word_t b_i [STAGES];
  word_t s_i [STAGES];
  logic  c_i [STAGES];
  logic  v_i [STAGES];

  // Inter-stage registers (the last stage registers into the output regs).
  word_t a_p   [STAGES];
  word_t b_p   [STAGES];
  word_t s_p   [STAGES];
  logic  c_p   [STAGES];
  logic  vld_p [STAGES];

  logic [SW:0] add_w [STAGES];
  word_t       s_w   [STAGES];

  logic  out_valid_r;
  word_t sum_r;
  logic  cout_r;
  logic  ovf_r;

  assign adv          = bus.out_ready | ~out_valid_r;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1, so cin is forced to 1 and ignored.
  assign a_i[0] = bus.a;
  assign b_i[0] = bus.sub ? ~bus.b : bus.b;
  assign s_i[0] = '0;
  assign c_i[0] = bus.sub | bus.cin;
  assign v_i[0] = bus.in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign a_i[k] = a_p[k-1];
      assign b_i[k] = b_p[k-1];
      assign s_i[k] = s_p[k-1];
      assign c_i[k] = c_p[k-1];
      assign v_i[k] = vld_p[k-1];
    end

    assign add_w[k] = slice_add(a_i[k][k*SW +: SW], b_i[k][k*SW +: SW], c_i[k]);
    assign s_w[k]   = put_slice(s_i[k], add_w[k][SW-1:0], k);

    if (k < STAGES - 1) begin : g_mid
      // ---- stage k -> stage k+1 boundary ----
      // Valid bit of stage k: cleared on reset, moves with the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p[k] <= 1'b0;
        end else if (adv) begin
          vld_p[k] <= v_i[k];
        end
      end

      // Operand/partial-sum payload of stage k; only real beats load it.
      always_ff @(posedge clk) begin
        if (adv && v_i[k]) begin
          a_p[k] <= a_i[k];
          b_p[k] <= b_i[k];
          s_p[k] <= s_w[k];
          c_p[k] <= add_w[k][SW];
        end
      end
    end else begin : g_out
      // ---- final stage -> output boundary ----
      // Output registers: bubbles leave sum/cout/ovf untouched.
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_r <= 1'b0;
          sum_r       <= '0;
          cout_r      <= 1'b0;
          ovf_r       <= 1'b0;
        end else if (adv) begin
          out_valid_r <= v_i[k];
          if (v_i[k]) begin
            sum_r  <= s_w[k];
            cout_r <= add_w[k][SW];
            ovf_r  <= a_i[k][WIDTH-1] ^ b_i[k][WIDTH-1] ^ s_w[k][WIDTH-1]
                      ^ add_w[k][SW];
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: a 16-bit/4-stage instance driven by directed and
// random beats against an arithmetic reference queue, plus an 8-bit/1-stage
// instance for the single-register configuration.
module tb_pipe_add_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_add_sub_if #(.WIDTH(16)) bus ();
  pipe_add_sub_if #(.WIDTH(8))  bus1 ();

  pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t q[$];
  int nvec = 0;
  int nfail = 0;
  int ndeliv = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int deliv_cyc = 0;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int unsigned ua, ub, full;
    int sr, ci;
    ua = a;
    ub = b;
    ci = cin ? 1 : 0;
    if (sub) begin
      full = ua + 32'h10000 - ub;
      sr   = int'($signed(a)) - int'($signed(b));
    end else begin
      full = ua + ub + ci;
      sr   = int'($signed(a)) + int'($signed(b)) + ci;
    end
    r.s = full[15:0];
    r.c = full[16];
    r.o = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the
  // rising edge. Inputs are changed only right after the rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      acc_cyc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("extra_beat", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum",  {16'b0, bus.sum}, {16'b0, e.s});
        chk("cout", {31'b0, bus.cout}, {31'b0, e.c});
        chk("ovf",  {31'b0, bus.ovf}, {31'b0, e.o});
        ndeliv++;
        deliv_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic vld);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = vld;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    chk("drain_left", q.size(), 32'd0);
  endtask

  task automatic wait_deliv(input int n0);
    for (int i = 0; i < 12 && ndeliv == n0; i++) tick();
    chk("deliv_timeout", ndeliv, n0 + 1);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    bus1.sub       = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_sum",       {16'b0, bus.sum}, 32'd0);
    chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    chk("rst_cout_ovf",  {30'b0, bus.cout, bus.ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-stage 8-bit instance: result one edge after acceptance
    bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("s1_valid", {31'b0, bus1.out_valid}, 32'd1);
    chk("s1_sum",   {24'b0, bus1.sum}, 32'h0000_00FF);
    chk("s1_cout",  {31'b0, bus1.cout}, 32'd1);
    chk("s1_ovf",   {31'b0, bus1.ovf}, 32'd0);
    @(posedge clk);
    #1;
    chk("s1_bubble_valid", {31'b0, bus1.out_valid}, 32'd0);
    chk("s1_bubble_hold",  {24'b0, bus1.sum}, 32'h0000_00FF);

    // Carry wrap and latency
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    n0 = ndeliv;
    wait_deliv(n0);
    chk("latency", deliv_cyc - acc_cyc, 32'd4);
    chk("wrap_sum_seen", {16'b0, bus.sum}, 32'h0000_0000);

    // Signed overflow on add, then subtraction cases (cin ignored)
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); tick();
    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1); tick();
    drive(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1); tick();
    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1); tick();
    drive(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1); tick();
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drain();

    // Eight back-to-back beats: one result per cycle after the fill
    n0 = ndeliv;
    for (int i = 0; i < 8; i++) begin
      drive(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0, 1'b1);
      chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("b2b_half", ndeliv - n0, 32'd4);
    repeat (4) tick();
    chk("b2b_all", ndeliv - n0, 32'd8);

    // Fill with output blocked, hold 5 cycles, then release
    bus.out_ready = 1'b0;
    n0 = ndeliv;
    for (int i = 0; i < 6; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    chk("stall_accepted", q.size(), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready",  {31'b0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_sum_frozen", {16'b0, bus.sum}, {16'b0, q[0].s});
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    drain();
    chk("stall_delivered", ndeliv - n0, 32'd4);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_sum",       {16'b0, bus.sum}, 32'd0);
    chk("arst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_stale", {31'b0, bus.out_valid}, 32'd0);
    end

    // Random traffic with random back-pressure
    n0 = ndeliv;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = ra;
      drive(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    drain();
    tick();
    chk("final_idle", {31'b0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", nvec);
    $fatal(1, "timeout");
  end

endmodule
